vector_decode_sequencer: RTL and testbench
==========================================

// Module: vector_decode_sequencer
// PURPOSE
//  Pipelined, parametrised successor to the single-cycle control decoder.
//  - Accepts one instruction via valid/ready; decodes Op/Funct/Rd into datapath controls.
//  - Holds the decoded controls in a register.
//  - Replays them for one beat (scalar) or ceil(VLEN/LANES) beats (vector), each tagged with beat index.
//  - Sits between fetch and the vector register file/ALU lanes.
// PARAMETERS
//  VLEN   16  elements per vector register
//  LANES  4   elements processed per beat
//  BEAT_W $clog2(ceil(VLEN/LANES)) (min 1)  width of beat index
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high
//  in_valid    in   1       instruction offered
//  in_ready    out  1       sequencer accepts this cycle
//  in_op       in   2       00 data-proc, 01 memory, 10 branch, 11 reserved
//  in_funct    in   6       [5]=I, [4:1]=cmd, [0]=S/L
//  in_rd       in   4       destination register
//  in_vec      in   1       1 = vector instruction
//  out_valid   out  1       control beat valid
//  out_ready   in   1       downstream consumes beat
//  RegW, MemW, MemToReg  out 1 each   register/memory control
//  ALUSrc      out  2       [1]=imm operand B, [0]=pass-B (MOV)
//  ImmSrc      out  2       00 imm8, 01 imm12, 10 imm24
//  RegSrc      out  2       [1]=store reads Rd, [0]=branch reads PC
//  ALUControl  out  3       000 ADD,001 SUB,010 AND,011 ORR,100 EOR,101 MOV
//  beat_idx    out  BEAT_W  current beat (element base = beat_idx*LANES)
//  last_beat   out  1       final beat of current instruction
//  illegal     out  1       undecodable instruction flag
// BEHAVIOUR
//  - Reset (async): state IDLE, every output register 0, in_ready 0 while reset asserted.
//  - FSM IDLE -> ISSUE on in_valid&in_ready; ISSUE -> IDLE when out_valid&out_ready&last_beat and no new accept.
//  - Latency: instruction accepted at edge N -> out_valid=1 after edge N (registered outputs).
//  - in_ready = (state==IDLE) | (out_valid&out_ready&last_beat): back-to-back with zero bubble.
//  - Stall: while out_valid&!out_ready, every output holds its value exactly; beat_idx does not advance.
//  - Beat count: scalar or illegal -> 1 beat (last_beat=1, beat_idx=0).
//    Vector -> BEATS; beat_idx 0..BEATS-1, +1 per handshake; last_beat = (beat_idx==BEATS-1).
//  - Decode, Op 00: RegW=1, ALUSrc[1]=funct[5], ImmSrc=00; ALUControl from cmd:
//    0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV (ALUSrc[0]=1); other cmd -> illegal.
//  - Decode, Op 01: ALUSrc[1]=1, ImmSrc=01, ALUControl=ADD.
//    funct[0]=1 load: RegW=1, MemToReg=1. funct[0]=0 store: MemW=1, RegSrc[1]=1.
//  - Decode, Op 10: ImmSrc=10, RegSrc[0]=1, ALUSrc[1]=1, ALUControl=ADD, no writes. Branch with in_vec=1 -> illegal.
//  - Illegal also for Op 11, and for in_vec=1 with in_rd==15.
//    Illegal beat: illegal=1, RegW=MemW=MemToReg=0, other controls 0.
//  - Reset asserted mid-sequence: remaining beats discarded, next accept starts at beat 0.
// CONFIGURATION
//  - VDEC_TAIL_MASK_EN defined: adds port lane_mask out LANES; BEATS=ceil(VLEN/LANES).
//    Last vector beat masks lanes >= VLEN%LANES (when nonzero). Other beats and scalar beats: all ones. Reset value 0.
//  - Undefined: no lane_mask port; BEATS=VLEN/LANES; elaboration $error if VLEN%LANES!=0.
// STRUCTURE
//  - Package vdec_pkg: op_e, alu_ctrl_e, imm_src constants, state_e {IDLE,ISSUE}, ctrl_t struct of all control outputs.
//  - Sub-module vdec_ctrl_rom: combinational op/funct/rd/vec -> ctrl_t + illegal.
//    Top holds the FSM, beat counter and output register.
// TESTING
//  1 Scalar ADD op=00 funct=001000 rd=2 vec=0, out_ready=1 -> one beat next cycle: RegW=1, ALUControl=000, last_beat=1.
//  2 Vector SUB op=00 funct=000100 vec=1, VLEN=16, LANES=4 -> 4 beats, beat_idx 0,1,2,3; last_beat only on 3.
//  3 out_ready low 3 cycles at beat 1 -> outputs frozen, beat_idx=1 held, in_ready=0.
//  4 Back-to-back load (op=01 funct=100001) after vector last beat -> in_ready=1 that cycle, no bubble, MemToReg=1.
//  5 Op=11, vector branch, vec rd=15, cmd 1111 -> illegal=1, RegW=MemW=0, single beat.
//  6 Reset at beat 2 -> out_valid=0 immediately; next vector starts beat 0. With tail mask, VLEN=10, LANES=4: last lane_mask=0011.

Source files
------------

// File: rtl/vector_decode_sequencer_pkg.sv
// vdec_pkg: shared types, encodings and sizing helpers for the vector decode sequencer.
`default_nettype none

package vdec_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100,
        ALU_MOV = 3'b101
    } alu_ctrl_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef struct packed {
        logic      RegW;
        logic      MemW;
        logic      MemToReg;
        logic [1:0] ALUSrc;
        logic [1:0] ImmSrc;
        logic [1:0] RegSrc;
        alu_ctrl_e ALUControl;
    } ctrl_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int calc_beat_w(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vector_decode_sequencer_if.sv
// Instruction-in / control-beat-out bundle; lane_mask exists only with VDEC_TAIL_MASK_EN.
`default_nettype none

interface vector_decode_sequencer_if #(
    parameter int VLEN  = 16,
    parameter int LANES = 4
);
    import vdec_pkg::*;

    localparam int BEAT_W = calc_beat_w(ceil_div(VLEN, LANES));

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [5:0]        in_funct;
    logic [3:0]        in_rd;
    logic              in_vec;
    logic              out_valid;
    logic              out_ready;
    logic              RegW;
    logic              MemW;
    logic              MemToReg;
    logic [1:0]        ALUSrc;
    logic [1:0]        ImmSrc;
    logic [1:0]        RegSrc;
    logic [2:0]        ALUControl;
    logic [BEAT_W-1:0] beat_idx;
    logic              last_beat;
    logic              illegal;
`ifdef VDEC_TAIL_MASK_EN
    logic [LANES-1:0]  lane_mask;
`endif

    modport master (
        output in_valid, in_op, in_funct, in_rd, in_vec, out_ready,
        input  in_ready, out_valid, RegW, MemW, MemToReg, ALUSrc, ImmSrc, RegSrc,
               ALUControl, beat_idx, last_beat, illegal
`ifdef VDEC_TAIL_MASK_EN
        , input lane_mask
`endif
    );

    modport slave (
        input  in_valid, in_op, in_funct, in_rd, in_vec, out_ready,
        output in_ready, out_valid, RegW, MemW, MemToReg, ALUSrc, ImmSrc, RegSrc,
               ALUControl, beat_idx, last_beat, illegal
`ifdef VDEC_TAIL_MASK_EN
        , output lane_mask
`endif
    );

endinterface

`default_nettype wire

// File: rtl/vector_decode_sequencer_ctrl_rom.sv
// vdec_ctrl_rom: combinational op/funct/rd/vec -> datapath controls plus illegal flag.
`default_nettype none

module vdec_ctrl_rom
    import vdec_pkg::*;
(
    input  logic [1:0] op_i,
    input  logic [5:0] funct_i,
    input  logic [3:0] rd_i,
    input  logic       vec_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o
);

    logic [3:0] w_cmd;
    ctrl_t      w_ctrl;
    logic       w_illegal;

    assign w_cmd = funct_i[4:1];

    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        case (op_e'(op_i))
            OP_DP: begin
                w_ctrl.RegW      = 1'b1;
                w_ctrl.ALUSrc[1] = funct_i[5];
                w_ctrl.ImmSrc    = IMM_8;
                case (w_cmd)
                    CMD_ADD: w_ctrl.ALUControl = ALU_ADD;
                    CMD_SUB: w_ctrl.ALUControl = ALU_SUB;
                    CMD_AND: w_ctrl.ALUControl = ALU_AND;
                    CMD_ORR: w_ctrl.ALUControl = ALU_ORR;
                    CMD_EOR: w_ctrl.ALUControl = ALU_EOR;
                    CMD_MOV: begin
                        w_ctrl.ALUControl = ALU_MOV;
                        w_ctrl.ALUSrc[0]  = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_MEM: begin
                w_ctrl.ALUSrc[1]  = 1'b1;
                w_ctrl.ImmSrc     = IMM_12;
                w_ctrl.ALUControl = ALU_ADD;
                if (funct_i[0]) begin
                    w_ctrl.RegW     = 1'b1;
                    w_ctrl.MemToReg = 1'b1;
                end else begin
                    w_ctrl.MemW      = 1'b1;
                    w_ctrl.RegSrc[1] = 1'b1;
                end
            end
            OP_BR: begin
                w_ctrl.ImmSrc     = IMM_24;
                w_ctrl.RegSrc[0]  = 1'b1;
                w_ctrl.ALUSrc[1]  = 1'b1;
                w_ctrl.ALUControl = ALU_ADD;
                w_illegal         = vec_i;
            end
            default: w_illegal = 1'b1;
        endcase
        // r15 is the PC and has no vector register counterpart
        if (vec_i && (rd_i == 4'd15)) begin
            w_illegal = 1'b1;
        end
        if (w_illegal) begin
            w_ctrl = '0;
        end
    end

    assign ctrl_o    = w_ctrl;
    assign illegal_o = w_illegal;

endmodule

`default_nettype wire

// File: rtl/vector_decode_sequencer.sv
// vector_decode_sequencer: accepts an instruction, registers its decoded controls and replays them per beat.
// Optional VDEC_TAIL_MASK_EN adds lane_mask and allows VLEN not a multiple of LANES.
`default_nettype none

module vector_decode_sequencer #(
    parameter int VLEN  = 16,
    parameter int LANES = 4
) (
    input  wire logic                clk,
    input  wire logic                reset,
    vector_decode_sequencer_if.slave bus_if
);
    import vdec_pkg::*;

    localparam int BEAT_W = calc_beat_w(ceil_div(VLEN, LANES));
`ifdef VDEC_TAIL_MASK_EN
    localparam int              BEATS     = ceil_div(VLEN, LANES);
    localparam int              TAIL      = VLEN % LANES;
    localparam logic [LANES-1:0] ONES     = {LANES{1'b1}};
    localparam logic [LANES-1:0] TAIL_MASK = (TAIL == 0) ? ONES : LANES'((64'd1 << TAIL) - 64'd1);
`else
    localparam int BEATS = VLEN / LANES;
    if ((VLEN % LANES) != 0) begin : g_vlen_check
        $error("VLEN must be a multiple of LANES unless VDEC_TAIL_MASK_EN is defined");
    end
`endif
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              illegal_q, illegal_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    ctrl_t             ctrl_q, ctrl_d;
`ifdef VDEC_TAIL_MASK_EN
    logic [LANES-1:0]  mask_q, mask_d;
`endif

    ctrl_t             w_rom_ctrl;
    logic              w_rom_illegal;
    logic              w_multi;
    logic              w_fire;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_load;
    logic [BEAT_W-1:0] w_beat_nxt;

    vdec_ctrl_rom u_ctrl_rom (
        .op_i      (bus_if.in_op),
        .funct_i   (bus_if.in_funct),
        .rd_i      (bus_if.in_rd),
        .vec_i     (bus_if.in_vec),
        .ctrl_o    (w_rom_ctrl),
        .illegal_o (w_rom_illegal)
    );

    assign w_multi    = bus_if.in_vec & ~w_rom_illegal;
    assign w_fire     = valid_q & bus_if.out_ready;
    // Accepting while the final beat drains gives zero-bubble back-to-back issue.
    assign w_in_ready = ~reset & ((state_q == IDLE) | (w_fire & last_q));
    assign w_accept   = bus_if.in_valid & w_in_ready;
    assign w_beat_nxt = beat_q + BEAT_W'(1);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        last_d    = last_q;
        illegal_d = illegal_q;
        beat_d    = beat_q;
        ctrl_d    = ctrl_q;
`ifdef VDEC_TAIL_MASK_EN
        mask_d    = mask_q;
`endif
        w_load    = 1'b0;
        case (state_q)
            IDLE: w_load = w_accept;
            ISSUE: begin
                if (w_fire) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        w_load  = w_accept;
                    end else begin
                        beat_d = w_beat_nxt;
                        last_d = (w_beat_nxt == LAST_BEAT);
`ifdef VDEC_TAIL_MASK_EN
                        mask_d = (w_beat_nxt == LAST_BEAT) ? TAIL_MASK : ONES;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_load) begin
            state_d   = ISSUE;
            valid_d   = 1'b1;
            ctrl_d    = w_rom_ctrl;
            illegal_d = w_rom_illegal;
            beat_d    = '0;
            last_d    = ~w_multi | (BEATS == 1);
`ifdef VDEC_TAIL_MASK_EN
            mask_d    = (w_multi && (BEATS == 1)) ? TAIL_MASK : ONES;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            illegal_q <= 1'b0;
            beat_q    <= '0;
            ctrl_q    <= '0;
`ifdef VDEC_TAIL_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            illegal_q <= illegal_d;
            beat_q    <= beat_d;
            ctrl_q    <= ctrl_d;
`ifdef VDEC_TAIL_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign bus_if.in_ready   = w_in_ready;
    assign bus_if.out_valid  = valid_q;
    assign bus_if.RegW       = ctrl_q.RegW;
    assign bus_if.MemW       = ctrl_q.MemW;
    assign bus_if.MemToReg   = ctrl_q.MemToReg;
    assign bus_if.ALUSrc     = ctrl_q.ALUSrc;
    assign bus_if.ImmSrc     = ctrl_q.ImmSrc;
    assign bus_if.RegSrc     = ctrl_q.RegSrc;
    assign bus_if.ALUControl = ctrl_q.ALUControl;
    assign bus_if.beat_idx   = beat_q;
    assign bus_if.last_beat  = last_q;
    assign bus_if.illegal    = illegal_q;
`ifdef VDEC_TAIL_MASK_EN
    assign bus_if.lane_mask  = mask_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_decode_sequencer.sv
// Scoreboard bench: driver pushes expected beats on accept, monitor pops and compares on each presented beat.
`default_nettype none

module tb_vector_decode_sequencer;

    localparam int LANES = 4;
`ifdef VDEC_TAIL_MASK_EN
    localparam int VLEN  = 10;
    localparam int BEATS = (VLEN + LANES - 1) / LANES;
`else
    localparam int VLEN  = 16;
    localparam int BEATS = VLEN / LANES;
`endif

    typedef struct {
        int regw, memw, memtoreg, alusrc, immsrc, regsrc, aluctl, illegal, beat, last, mask;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   ready_pct = 100;
    bit   stall_b1 = 1'b0;
    int   stall_cnt = 0;

    vector_decode_sequencer_if #(.VLEN(VLEN), .LANES(LANES)) bus_if ();

    vector_decode_sequencer #(.VLEN(VLEN), .LANES(LANES)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input logic v);
        exp_t e = '{default: 0};
        int cmd = int'(f[4:1]);
        bit dp_ok = cmd inside {0, 1, 2, 4, 12, 13};
        if (op == 2'd3 || (v && rd == 4'd15) || (op == 2'd2 && v) || (op == 2'd0 && !dp_ok)) begin
            e.illegal = 1;
            return e;
        end
        case (op)
            2'd0: begin
                e.regw   = 1;
                e.alusrc = 2 * int'(f[5]) + ((cmd == 13) ? 1 : 0);
                e.aluctl = (cmd == 4) ? 0 : (cmd == 2) ? 1 : (cmd == 0) ? 2 : (cmd == 12) ? 3 : (cmd == 1) ? 4 : 5;
            end
            2'd1: begin
                e.alusrc = 2;
                e.immsrc = 1;
                if (f[0]) begin e.regw = 1; e.memtoreg = 1; end
                else begin e.memw = 1; e.regsrc = 2; end
            end
            default: begin
                e.immsrc = 2;
                e.regsrc = 1;
                e.alusrc = 2;
            end
        endcase
        return e;
    endfunction

    task automatic push_expected(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input logic v);
        exp_t e = model(op, f, rd, v);
        int   n = (v && e.illegal == 0) ? BEATS : 1;
        for (int b = 0; b < n; b++) begin
            e.beat = b;
            e.last = (b == n - 1) ? 1 : 0;
            e.mask = (n > 1 && b == n - 1 && (VLEN % LANES) != 0) ? ((1 << (VLEN % LANES)) - 1) : ((1 << LANES) - 1);
            q.push_back(e);
        end
    endtask

    task automatic compare_out(input exp_t e);
        check("RegW", int'(bus_if.RegW), e.regw);
        check("MemW", int'(bus_if.MemW), e.memw);
        check("MemToReg", int'(bus_if.MemToReg), e.memtoreg);
        check("ALUSrc", int'(bus_if.ALUSrc), e.alusrc);
        check("ImmSrc", int'(bus_if.ImmSrc), e.immsrc);
        check("RegSrc", int'(bus_if.RegSrc), e.regsrc);
        check("ALUControl", int'(bus_if.ALUControl), e.aluctl);
        check("illegal", int'(bus_if.illegal), e.illegal);
        check("beat_idx", int'(bus_if.beat_idx), e.beat);
        check("last_beat", int'(bus_if.last_beat), e.last);
`ifdef VDEC_TAIL_MASK_EN
        check("lane_mask", int'(bus_if.lane_mask), e.mask);
`endif
    endtask

    // Monitor / consumer: drives out_ready, checks every cycle against the scoreboard.
    initial begin
        exp_t zero = '{default: 0};
        bus_if.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                bus_if.out_ready = 1'b0;
                stall_cnt--;
            end else if (stall_b1 && q.size() > 0 && q[0].beat == 1) begin
                stall_b1 = 1'b0;
                stall_cnt = 2;
                bus_if.out_ready = 1'b0;
            end else begin
                bus_if.out_ready = ($urandom_range(0, 99) < ready_pct);
            end
            #1;
            if (reset) begin
                check("reset_out_valid", int'(bus_if.out_valid), 0);
                check("reset_in_ready", int'(bus_if.in_ready), 0);
                compare_out(zero);
            end else if (q.size() == 0) begin
                check("idle_out_valid", int'(bus_if.out_valid), 0);
                check("idle_in_ready", int'(bus_if.in_ready), 1);
            end else begin
                check("out_valid", int'(bus_if.out_valid), 1);
                check("in_ready", int'(bus_if.in_ready), (bus_if.out_ready && q[0].last == 1) ? 1 : 0);
                compare_out(q[0]);
                if (bus_if.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input logic v);
        bit done = 1'b0;
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_op    = op;
        bus_if.in_funct = f;
        bus_if.in_rd    = rd;
        bus_if.in_vec   = v;
        for (int i = 0; i < 100 && !done; i++) begin
            #2;
            if (bus_if.in_ready) begin
                push_expected(op, f, rd, v);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            check("accept_timeout", 0, 1);
            bus_if.in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_if.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 500 && q.size() != 0; i++) idle(1);
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit found = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_op    = '0;
        bus_if.in_funct = '0;
        bus_if.in_rd    = '0;
        bus_if.in_vec   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        send(2'b00, 6'b001000, 4'd2, 1'b0);          // scalar ADD
        send(2'b00, 6'b000100, 4'd3, 1'b1);          // vector SUB
        stall_b1 = 1'b1;
        send(2'b00, 6'b000100, 4'd4, 1'b1);          // vector SUB, stalled at beat 1
        send(2'b01, 6'b100001, 4'd5, 1'b0);          // load back-to-back
        send(2'b01, 6'b000000, 4'd6, 1'b0);          // store
        send(2'b00, 6'b111010, 4'd7, 1'b1);          // vector MOV imm
        send(2'b11, 6'b001000, 4'd1, 1'b0);          // reserved op
        send(2'b10, 6'b000000, 4'd0, 1'b1);          // vector branch
        send(2'b00, 6'b001000, 4'd15, 1'b1);         // vector to r15
        send(2'b00, 6'b011110, 4'd1, 1'b0);          // cmd 1111
        send(2'b10, 6'b000000, 4'd0, 1'b0);          // scalar branch
        drain();

        // Reset while the third beat of a vector is presented.
        send(2'b00, 6'b000100, 4'd6, 1'b1);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            bus_if.in_valid = 1'b0;
            if (q.size() > 0 && q[0].beat == 2) found = 1'b1;
        end
        check("reached_beat2", int'(found), 1);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        send(2'b00, 6'b001000, 4'd7, 1'b1);
        drain();

        ready_pct = 65;
        repeat (80) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom), 1'($urandom));
        end
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
